onehot_regfile: RTL and testbench

- Register file that consumes the one-hot operand selects (Aselect, Bselect, Dselect) produced by the instruction decode stage.
- Drives registered A/B operand buses to the ALU and writes ALU results back to the destination register.
- Destination select is delayed internally by a parameterised number of cycles so each write lines up with its ALU result.
- Encodes every one-hot select back to a 5-bit index, checks that it is legal, and flags violations.

---
 rtl/onehot_regfile_pkg.sv | 22 ++
 rtl/onehot_regfile_if.sv | 33 +++
 rtl/onehot_regfile_enc32.sv | 28 ++
 rtl/onehot_regfile.sv | 98 +++++++++
 tb/tb_onehot_regfile.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/onehot_regfile_pkg.sv
// +----------------------------------------------------------------------+
// | regfile_pkg : shared sizes and write-pipe entry type for the regfile  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package regfile_pkg;

  localparam int NREGS      = 32;
  localparam int IDX_W      = 5;
  localparam int WB_LAT_MAX = 4;

  localparam logic [IDX_W-1:0] R0 = '0;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/onehot_regfile_if.sv
// +----------------------------------------------------------------------+
// | onehot_regfile_if : decode/ALU-side bus of the one-hot register file  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

interface onehot_regfile_if #(
  parameter int WIDTH = 32
);

  logic [31:0]      Aselect;
  logic [31:0]      Bselect;
  logic [31:0]      Dselect;
  logic             wen;
  logic [WIDTH-1:0] dbus;
  logic [WIDTH-1:0] abus;
  logic [WIDTH-1:0] bbus;
  logic             sel_err;
  logic             wb_busy;

  modport master (
    output Aselect, Bselect, Dselect, wen, dbus,
    input  abus, bbus, sel_err, wb_busy
  );

  modport slave (
    input  Aselect, Bselect, Dselect, wen, dbus,
    output abus, bbus, sel_err, wb_busy
  );

endinterface

`default_nettype wire

// File: rtl/onehot_regfile_enc32.sv
// +----------------------------------------------------------------------+
// | onehot_enc32 : 32-bit one-hot to 5-bit index encoder with legality    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module onehot_enc32
  import regfile_pkg::*;
(
  input  logic [NREGS-1:0] onehot_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             legal_o
);

  always_comb begin
    idx_o = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (onehot_i[i]) begin
        idx_o = idx_o | IDX_W'(i);
      end
    end
    // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
    legal_o = (onehot_i != '0) && ((onehot_i & (onehot_i - NREGS'(1))) == '0);
  end

endmodule

`default_nettype wire

// File: rtl/onehot_regfile.sv
// +----------------------------------------------------------------------+
// | onehot_regfile : 32-entry regfile with one-hot selects, registered    |
// | read ports, delayed write-back pipe and commit-to-read bypass. Rev 1.0|
// +----------------------------------------------------------------------+
`default_nettype none

module onehot_regfile
  import regfile_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int WB_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  onehot_regfile_if.slave  bus
);

  localparam int LAT = (WB_LAT < 1) ? 1 : ((WB_LAT > WB_LAT_MAX) ? WB_LAT_MAX : WB_LAT);

  logic [IDX_W-1:0] idx_a, idx_b, idx_d;
  logic             legal_a, legal_b, legal_d;

  onehot_enc32 u_enc_a (.onehot_i(bus.Aselect), .idx_o(idx_a), .legal_o(legal_a));
  onehot_enc32 u_enc_b (.onehot_i(bus.Bselect), .idx_o(idx_b), .legal_o(legal_b));
  onehot_enc32 u_enc_d (.onehot_i(bus.Dselect), .idx_o(idx_d), .legal_o(legal_d));

  logic [WIDTH-1:0] regs_q [NREGS];
  wb_entry_t        pipe_q [LAT];
  wb_entry_t        cap_d;
  wb_entry_t        commit;
  logic [WIDTH-1:0] abus_q, abus_d;
  logic [WIDTH-1:0] bbus_q, bbus_d;
  logic             sel_err_q, sel_err_d;
  logic             busy;

  function automatic logic [WIDTH-1:0] read_mux(
    input logic             legal,
    input logic [IDX_W-1:0] idx,
    input wb_entry_t        wb,
    input logic [WIDTH-1:0] wdata,
    input logic [WIDTH-1:0] rdata
  );
    if (!legal || idx == R0) begin
      return '0;
    end
    if (wb.valid && wb.idx == idx) begin
      return wdata;
    end
    return rdata;
  endfunction

  always_comb begin
    // r0 writes never enter the pipe, so they can neither commit nor show as busy.
    cap_d.valid = legal_d & bus.wen & (idx_d != R0);
    cap_d.idx   = idx_d;
    commit      = pipe_q[LAT-1];
    abus_d      = read_mux(legal_a, idx_a, commit, bus.dbus, regs_q[idx_a]);
    bbus_d      = read_mux(legal_b, idx_b, commit, bus.dbus, regs_q[idx_b]);
    sel_err_d   = sel_err_q | ~legal_a | ~legal_b | (~legal_d & bus.wen);
    busy        = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      busy = busy | pipe_q[i].valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      for (int i = 0; i < LAT; i++) begin
        pipe_q[i] <= '0;
      end
      abus_q    <= '0;
      bbus_q    <= '0;
      sel_err_q <= 1'b0;
    end else begin
      pipe_q[0] <= cap_d;
      for (int i = 1; i < LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
      if (commit.valid) begin
        regs_q[commit.idx] <= bus.dbus;
      end
      abus_q    <= abus_d;
      bbus_q    <= bbus_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign bus.abus    = abus_q;
  assign bus.bbus    = bbus_q;
  assign bus.sel_err = sel_err_q;
  assign bus.wb_busy = busy;

endmodule

`default_nettype wire

// File: tb/tb_onehot_regfile.sv
// +----------------------------------------------------------------------+
// | tb_onehot_regfile : directed self-checking bench, WB_LAT=1 and 3      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_onehot_regfile;

  logic clk;
  logic rst_n;
  logic rst3_n;
  int   tests;
  int   fails;

  onehot_regfile_if #(.WIDTH(32)) if1 ();
  onehot_regfile_if #(.WIDTH(32)) if3 ();

  onehot_regfile #(.WIDTH(32), .WB_LAT(1)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  onehot_regfile #(.WIDTH(32), .WB_LAT(3)) u_dut3 (
    .clk   (clk),
    .rst_n (rst3_n),
    .bus   (if3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] bit_sel(input int n);
    return 32'h1 << n;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle1();
    if1.Aselect = bit_sel(0);
    if1.Bselect = bit_sel(0);
    if1.Dselect = bit_sel(0);
    if1.wen     = 1'b0;
    if1.dbus    = 32'h0;
  endtask

  task automatic idle3();
    if3.Aselect = bit_sel(0);
    if3.Bselect = bit_sel(0);
    if3.Dselect = bit_sel(0);
    if3.wen     = 1'b0;
    if3.dbus    = 32'h0;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    rst3_n = 1'b0;
    idle1();
    idle3();
    step();
    tests++;
    if (if1.abus !== 32'h0 || if1.bbus !== 32'h0 || if1.sel_err !== 1'b0 || if1.wb_busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs abus=%h bbus=%h sel_err=%b wb_busy=%b expected all 0",
               if1.abus, if1.bbus, if1.sel_err, if1.wb_busy);
    end
    step();
    rst_n  = 1'b1;
    rst3_n = 1'b1;
    step();
    for (int r = 1; r < 32; r++) begin
      if1.Aselect = bit_sel(r);
      if1.Bselect = bit_sel(r);
      step();
      tests++;
      if (if1.abus !== 32'h0 || if1.bbus !== 32'h0) begin
        fails++;
        $display("FAIL reset_reg_r%0d abus=%h bbus=%h expected 0", r, if1.abus, if1.bbus);
      end
    end
    idle1();
    step();
    tests++;
    if (if1.sel_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_sel_err got=%b expected=0", if1.sel_err);
    end
  endtask

  task automatic test_basic_write_read();
    if1.Dselect = bit_sel(5);
    if1.wen     = 1'b1;
    step();
    if1.Dselect = bit_sel(0);
    if1.wen     = 1'b0;
    if1.dbus    = 32'hDEADBEEF;
    tests++;
    if (if1.wb_busy !== 1'b1) begin
      fails++;
      $display("FAIL basic_busy got=%b expected=1", if1.wb_busy);
    end
    step();
    if1.dbus = 32'h0;
    tests++;
    if (if1.wb_busy !== 1'b0) begin
      fails++;
      $display("FAIL basic_busy_clear got=%b expected=0", if1.wb_busy);
    end
    step();
    if1.Aselect = bit_sel(5);
    step();
    tests++;
    if (if1.abus !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL basic_read abus=%h expected=DEADBEEF", if1.abus);
    end
    idle1();
  endtask

  task automatic test_bypass();
    if1.Dselect = bit_sel(7);
    if1.wen     = 1'b1;
    step();
    if1.Dselect = bit_sel(0);
    if1.wen     = 1'b0;
    if1.dbus    = 32'h12345678;
    if1.Aselect = bit_sel(7);
    if1.Bselect = bit_sel(7);
    step();
    tests++;
    if (if1.abus !== 32'h12345678 || if1.bbus !== 32'h12345678) begin
      fails++;
      $display("FAIL bypass abus=%h bbus=%h expected=12345678", if1.abus, if1.bbus);
    end
    idle1();
    step();
  endtask

  task automatic test_back_to_back();
    if1.Dselect = bit_sel(3);
    if1.wen     = 1'b1;
    step();
    if1.dbus = 32'h00000111;
    step();
    if1.Dselect = bit_sel(0);
    if1.wen     = 1'b0;
    if1.dbus    = 32'h00000222;
    step();
    if1.dbus    = 32'h0;
    if1.Aselect = bit_sel(3);
    if1.Bselect = bit_sel(5);
    step();
    tests++;
    if (if1.abus !== 32'h00000222 || if1.bbus !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL back_to_back abus=%h bbus=%h expected=00000222/DEADBEEF", if1.abus, if1.bbus);
    end
    idle1();
  endtask

  task automatic test_r0_protect();
    if1.Dselect = bit_sel(0);
    if1.wen     = 1'b1;
    step();
    if1.wen  = 1'b0;
    if1.dbus = 32'hFFFFFFFF;
    tests++;
    if (if1.wb_busy !== 1'b0) begin
      fails++;
      $display("FAIL r0_busy got=%b expected=0", if1.wb_busy);
    end
    step();
    if1.dbus    = 32'h0;
    if1.Aselect = bit_sel(0);
    step();
    tests++;
    if (if1.abus !== 32'h0) begin
      fails++;
      $display("FAIL r0_read abus=%h expected=0", if1.abus);
    end
    idle1();
  endtask

  task automatic test_illegal_d_no_wen();
    if1.Dselect = 32'h0;
    if1.wen     = 1'b0;
    step();
    step();
    tests++;
    if (if1.sel_err !== 1'b0) begin
      fails++;
      $display("FAIL illegal_d_wen0 sel_err=%b expected=0", if1.sel_err);
    end
    idle1();
  endtask

  task automatic test_illegal_a();
    if1.Aselect = bit_sel(5);
    step();
    if1.Aselect = 32'h00000003;
    step();
    tests++;
    if (if1.abus !== 32'h0 || if1.sel_err !== 1'b1) begin
      fails++;
      $display("FAIL illegal_a abus=%h sel_err=%b expected=0/1", if1.abus, if1.sel_err);
    end
    if1.Aselect = bit_sel(5);
    step();
    step();
    tests++;
    if (if1.sel_err !== 1'b1 || if1.abus !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL illegal_a_sticky sel_err=%b abus=%h expected=1/DEADBEEF", if1.sel_err, if1.abus);
    end
  endtask

  task automatic test_reset_midstream();
    if1.Aselect = bit_sel(5);
    if1.Bselect = bit_sel(3);
    step();
    rst_n = 1'b0;
    #1;
    tests++;
    if (if1.abus !== 32'h0 || if1.bbus !== 32'h0 || if1.sel_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_midstream abus=%h bbus=%h sel_err=%b expected all 0",
               if1.abus, if1.bbus, if1.sel_err);
    end
    step();
    rst_n = 1'b1;
    step();
    tests++;
    if (if1.abus !== 32'h0 || if1.bbus !== 32'h0) begin
      fails++;
      $display("FAIL reset_midstream_regs abus=%h bbus=%h expected 0", if1.abus, if1.bbus);
    end
    idle1();
  endtask

  task automatic test_illegal_d_wen();
    step();
    if1.Dselect = 32'h00000000;
    if1.wen     = 1'b1;
    step();
    idle1();
    tests++;
    if (if1.sel_err !== 1'b1 || if1.wb_busy !== 1'b0) begin
      fails++;
      $display("FAIL illegal_d_wen1 sel_err=%b wb_busy=%b expected=1/0", if1.sel_err, if1.wb_busy);
    end
  endtask

  task automatic test_lat3_latency();
    if3.Dselect = bit_sel(9);
    if3.wen     = 1'b1;
    step();
    if3.Dselect = bit_sel(0);
    if3.wen     = 1'b0;
    if3.dbus    = 32'h00000005;
    tests++;
    if (if3.wb_busy !== 1'b1) begin
      fails++;
      $display("FAIL lat3_busy got=%b expected=1", if3.wb_busy);
    end
    step();
    step();
    if3.dbus = 32'h0000CAFE;
    step();
    if3.dbus    = 32'h0;
    if3.Aselect = bit_sel(9);
    tests++;
    if (if3.wb_busy !== 1'b0) begin
      fails++;
      $display("FAIL lat3_busy_clear got=%b expected=0", if3.wb_busy);
    end
    step();
    tests++;
    if (if3.abus !== 32'h0000CAFE) begin
      fails++;
      $display("FAIL lat3_read abus=%h expected=0000CAFE", if3.abus);
    end
    idle3();
  endtask

  task automatic test_lat3_reset_midwrite();
    if3.Dselect = bit_sel(9);
    if3.wen     = 1'b1;
    step();
    if3.Dselect = bit_sel(0);
    if3.wen     = 1'b0;
    rst3_n      = 1'b0;
    step();
    rst3_n = 1'b1;
    step();
    if3.dbus = 32'hAAAA0000;
    tests++;
    if (if3.wb_busy !== 1'b0) begin
      fails++;
      $display("FAIL lat3_reset_busy got=%b expected=0", if3.wb_busy);
    end
    step();
    if3.dbus    = 32'h0;
    if3.Aselect = bit_sel(9);
    step();
    tests++;
    if (if3.abus !== 32'h0 || if3.wb_busy !== 1'b0) begin
      fails++;
      $display("FAIL lat3_reset_midwrite abus=%h wb_busy=%b expected=0/0", if3.abus, if3.wb_busy);
    end
    idle3();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_basic_write_read();
    test_bypass();
    test_back_to_back();
    test_r0_protect();
    test_illegal_d_no_wen();
    test_illegal_a();
    test_reset_midstream();
    test_illegal_d_wen();
    test_lat3_latency();
    test_lat3_reset_midwrite();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
